ycbcr_to_rgb: RTL and testbench
===============================

Name: ycbcr_to_rgb

Overview:
Pipelined full-range BT.601 YCbCr-to-RGB converter. It is the inverse of the existing RGB-to-YCbCr front end and is used to display or feed back processed frames.
- Takes one 8-bit Y/Cb/Cr pixel per accepted beat and produces one 8-bit R/G/B pixel.
- Valid/ready handshake on both sides.
- 3-stage fixed-point pipeline with saturation.

Parameters:
FRAC, 8, fractional bits of coefficients
C_RCR, 359, 1.402 x 2^FRAC (Cr term of R)
C_GCB, 88, 0.344136 x 2^FRAC (Cb term of G)
C_GCR, 183, 0.714136 x 2^FRAC (Cr term of G)
C_BCB, 454, 1.772 x 2^FRAC (Cb term of B)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  input pixel valid
in_ready  output  1  block can accept input this cycle
luma_ch  input  8  Y, unsigned 0..255
cb_ch  input  8  Cb, unsigned, offset 128
cr_ch  input  8  Cr, unsigned, offset 128
out_valid  output  1  output pixel valid
out_ready  input  1  downstream accepts output
red_ch  output  8  R, unsigned, saturated
green_ch  output  8  G, unsigned, saturated
blue_ch  output  8  B, unsigned, saturated

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is asynchronous and active-high.
- Reset values: out_valid=0, red_ch/green_ch/blue_ch=0, all stage valid bits=0, all pipeline data registers=0.
- Reset mid-stream discards in-flight pixels. No output appears until new input is accepted after rst deasserts.
- Global advance: adv = !out_valid | out_ready.
  - in_ready = adv (combinational from out_ready, documented path).
  - When adv=0, every stage register holds.
- Input transfer when in_valid & in_ready. Output transfer when out_valid & out_ready.
- S1 (on adv):
  - v1 <= in_valid.
  - y1 <= luma_ch.
  - cbd <= cb_ch - 128, crd <= cr_ch - 128 (signed 9-bit, range -128..127).
- S2 (on adv):
  - v2 <= v1, y2 <= y1.
  - pr = C_RCR*crd; pg = -(C_GCB*cbd) - (C_GCR*crd); pb = C_BCB*cbd.
  - All products signed, minimum 19 bits; the pg sum is 20 bits signed.
- S3 (on adv):
  - v3 = out_valid <= v2.
  - For each channel: t = y2 + ((p + 2^(FRAC-1)) >>> FRAC), using an arithmetic shift (floor).
  - Clamp: t<0 gives 0; t>255 gives 255; otherwise t[7:0].
- Latency: 3 clk from input transfer to out_valid when never stalled. Throughput is 1 pixel/clk.
- Bubbles (in_valid=0) propagate as invalid stages; downstream never sees them.
- Backpressure: while out_valid=1 & out_ready=0, red/green/blue and out_valid stay stable, in_ready=0, and no input is lost or duplicated.
- Simultaneous output transfer and new input in the same cycle: both occur and the pipeline shifts by one.
- Data on invalid stages is don't-care, but must not be X after reset.

Decomposition:
- Shared pixel package holds:
  - the 8-bit channel width constant;
  - the chroma offset constant 128;
  - the four coefficient defaults and FRAC, shared with the RGB-to-YCbCr block so the encode and decode sides stay consistent.
- One sub-module, ycc_clamp8: takes a signed sum and returns the saturated 8-bit value. It is instantiated 3 times in S3.

Test Plan:
- Grey: Y=128, Cb=128, Cr=128 with out_ready=1 -> after 3 clk, out_valid=1 and R=128, G=128, B=128.
- White, then saturated red, issued back-to-back:
  - Y=255, Cb=128, Cr=128 -> 255,255,255.
  - Y=76, Cb=85, Cr=255 -> R=254, G=0, B=0.
  - The two results appear on consecutive cycles.
- Clamp:
  - Y=255, Cb=128, Cr=255 -> R=255 (raw 433).
  - Y=0, Cb=0, Cr=128 -> B=0 (raw -227), R=0, G=44.
- Backpressure: stream 6 pixels and hold out_ready=0 for 4 clk mid-stream -> outputs are held stable, in_ready=0 while full, all 6 results arrive in order with no loss or duplication.
- Reset mid-stream: assert rst asynchronously (between clock edges) with 2 pixels in flight -> out_valid drops to 0 immediately, outputs read 0, and the first output after release comes only from post-reset input.

Source files
------------

// File: rtl/ycbcr_to_rgb_pkg.sv
// ============================================================
// ycbcr_to_rgb_pkg : pixel constants and BT.601 coefficients
// Rev 1.0
// ============================================================
`default_nettype none

package ycbcr_to_rgb_pkg;

  localparam int CH_W       = 8;
  localparam int CHROMA_OFS = 128;

  // Shared with the RGB-to-YCbCr encoder so both directions stay consistent.
  localparam int FRAC_DEFAULT  = 8;
  localparam int C_RCR_DEFAULT = 359;
  localparam int C_GCB_DEFAULT = 88;
  localparam int C_GCR_DEFAULT = 183;
  localparam int C_BCB_DEFAULT = 454;

  localparam int PROD_W = 20;
  localparam int SUM_W  = 12;

  // Round-half-up then floor shift back to integer pixel units.
  function automatic logic signed [SUM_W-1:0] round_frac(
    input logic signed [PROD_W-1:0] p,
    input int                       frac
  );
    logic signed [PROD_W:0] ps;
    ps = (PROD_W+1)'(p) + (PROD_W+1)'(1 << (frac - 1));
    return SUM_W'(ps >>> frac);
  endfunction

endpackage

`default_nettype wire

// File: rtl/ycc_clamp8.sv
// ============================================================
// ycc_clamp8 : saturate a signed sum into an unsigned channel
// Rev 1.0
// ============================================================
`default_nettype none

module ycc_clamp8
  import ycbcr_to_rgb_pkg::*;
#(
  parameter int IN_W = SUM_W
) (
  input  logic signed [IN_W-1:0] sum_in,
  output logic        [CH_W-1:0] sat_out
);

  localparam logic signed [IN_W-1:0] MAX_V = IN_W'((1 << CH_W) - 1);

  always_comb begin
    sat_out = sum_in[CH_W-1:0];
    if (sum_in[IN_W-1]) begin
      sat_out = '0;
    end else if (sum_in > MAX_V) begin
      sat_out = '1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/ycbcr_to_rgb.sv
// ============================================================
// ycbcr_to_rgb : 3-stage full-range BT.601 YCbCr to RGB converter
// Rev 1.0
// ============================================================
`default_nettype none

module ycbcr_to_rgb
  import ycbcr_to_rgb_pkg::*;
#(
  parameter int FRAC  = FRAC_DEFAULT,
  parameter int C_RCR = C_RCR_DEFAULT,
  parameter int C_GCB = C_GCB_DEFAULT,
  parameter int C_GCR = C_GCR_DEFAULT,
  parameter int C_BCB = C_BCB_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [CH_W-1:0] luma_ch,
  input  logic [CH_W-1:0] cb_ch,
  input  logic [CH_W-1:0] cr_ch,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [CH_W-1:0] red_ch,
  output logic [CH_W-1:0] green_ch,
  output logic [CH_W-1:0] blue_ch
);

  logic                     adv;
  logic                     v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic        [CH_W-1:0]   y1_q, y1_d, y2_q, y2_d;
  logic signed [CH_W:0]     cbd_q, cbd_d, crd_q, crd_d;
  logic signed [PROD_W-1:0] pr_q, pr_d, pg_q, pg_d, pb_q, pb_d;
  logic        [CH_W-1:0]   red_q, red_d, green_q, green_d, blue_q, blue_d;
  logic signed [SUM_W-1:0]  r_sum, g_sum, b_sum;
  logic        [CH_W-1:0]   r_sat, g_sat, b_sat;

  // Whole pipeline moves as one: a stalled output freezes every stage.
  assign adv      = !v3_q || out_ready;
  assign in_ready = adv;

  assign r_sum = $signed({{(SUM_W-CH_W){1'b0}}, y2_q}) + round_frac(pr_q, FRAC);
  assign g_sum = $signed({{(SUM_W-CH_W){1'b0}}, y2_q}) + round_frac(pg_q, FRAC);
  assign b_sum = $signed({{(SUM_W-CH_W){1'b0}}, y2_q}) + round_frac(pb_q, FRAC);

  ycc_clamp8 #(.IN_W(SUM_W)) u_clamp_r (.sum_in(r_sum), .sat_out(r_sat));
  ycc_clamp8 #(.IN_W(SUM_W)) u_clamp_g (.sum_in(g_sum), .sat_out(g_sat));
  ycc_clamp8 #(.IN_W(SUM_W)) u_clamp_b (.sum_in(b_sum), .sat_out(b_sat));

  always_comb begin
    v1_d    = v1_q;
    y1_d    = y1_q;
    cbd_d   = cbd_q;
    crd_d   = crd_q;
    v2_d    = v2_q;
    y2_d    = y2_q;
    pr_d    = pr_q;
    pg_d    = pg_q;
    pb_d    = pb_q;
    v3_d    = v3_q;
    red_d   = red_q;
    green_d = green_q;
    blue_d  = blue_q;
    if (adv) begin
      v1_d    = in_valid;
      y1_d    = luma_ch;
      cbd_d   = (CH_W+1)'($signed({1'b0, cb_ch}) - CHROMA_OFS);
      crd_d   = (CH_W+1)'($signed({1'b0, cr_ch}) - CHROMA_OFS);
      v2_d    = v1_q;
      y2_d    = y1_q;
      pr_d    = PROD_W'(C_RCR * crd_q);
      pg_d    = PROD_W'(-(C_GCB * cbd_q) - (C_GCR * crd_q));
      pb_d    = PROD_W'(C_BCB * cbd_q);
      v3_d    = v2_q;
      red_d   = r_sat;
      green_d = g_sat;
      blue_d  = b_sat;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q    <= 1'b0;
      y1_q    <= '0;
      cbd_q   <= '0;
      crd_q   <= '0;
      v2_q    <= 1'b0;
      y2_q    <= '0;
      pr_q    <= '0;
      pg_q    <= '0;
      pb_q    <= '0;
      v3_q    <= 1'b0;
      red_q   <= '0;
      green_q <= '0;
      blue_q  <= '0;
    end else begin
      v1_q    <= v1_d;
      y1_q    <= y1_d;
      cbd_q   <= cbd_d;
      crd_q   <= crd_d;
      v2_q    <= v2_d;
      y2_q    <= y2_d;
      pr_q    <= pr_d;
      pg_q    <= pg_d;
      pb_q    <= pb_d;
      v3_q    <= v3_d;
      red_q   <= red_d;
      green_q <= green_d;
      blue_q  <= blue_d;
    end
  end

  assign out_valid = v3_q;
  assign red_ch    = red_q;
  assign green_ch  = green_q;
  assign blue_ch   = blue_q;

endmodule

`default_nettype wire

// File: tb/tb_ycbcr_to_rgb.sv
// ============================================================
// tb_ycbcr_to_rgb : directed self-checking bench for ycbcr_to_rgb
// Rev 1.0
// ============================================================
`default_nettype none

module tb_ycbcr_to_rgb;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] luma_ch, cb_ch, cr_ch;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] red_ch, green_ch, blue_ch;

  ycbcr_to_rgb dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .luma_ch  (luma_ch),
    .cb_ch    (cb_ch),
    .cr_ch    (cr_ch),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .red_ch   (red_ch),
    .green_ch (green_ch),
    .blue_ch  (blue_ch)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  logic [23:0] exp_q[$];
  int          pop_cyc[$];
  logic        acc;
  int          acc_cyc;
  int          n0;
  int          bp_i, bp_c;

  // Hand-computed vectors: {Y, Cb, Cr} -> {R, G, B}
  logic [7:0]  bp_y  [6] = '{8'd128, 8'd255, 8'd76,  8'd255, 8'd0,   8'd100};
  logic [7:0]  bp_cb [6] = '{8'd128, 8'd128, 8'd85,  8'd128, 8'd0,   8'd150};
  logic [7:0]  bp_cr [6] = '{8'd128, 8'd128, 8'd255, 8'd255, 8'd128, 8'd100};
  logic [23:0] bp_e  [6] = '{24'h808080, 24'hFFFFFF, 24'hFE0000,
                             24'hFFA4FF, 24'h002C00, 24'h3D708B};

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One clock of stimulus; output observation happens just after the falling edge.
  task automatic step(input logic iv, input logic [7:0] y, input logic [7:0] cb,
                      input logic [7:0] cr, input logic [23:0] exp_rgb,
                      input logic ordy, output logic accepted);
    @(negedge clk);
    cyc++;
    in_valid  = iv;
    luma_ch   = y;
    cb_ch     = cb;
    cr_ch     = cr;
    out_ready = ordy;
    #1;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check_val("spurious_out", 32'd1, 32'd0);
      end else begin
        check_val("rgb", {8'h0, red_ch, green_ch, blue_ch}, {8'h0, exp_q.pop_front()});
        pop_cyc.push_back(cyc);
      end
    end else if (out_valid && !out_ready) begin
      check_val("stall_in_ready", {31'd0, in_ready}, 32'd0);
      if (exp_q.size() != 0)
        check_val("stall_hold", {8'h0, red_ch, green_ch, blue_ch}, {8'h0, exp_q[0]});
    end
    accepted = iv && in_ready;
    if (accepted) exp_q.push_back(exp_rgb);
  endtask

  task automatic idle(input int n);
    logic a;
    for (int k = 0; k < n; k++) step(1'b0, 8'd0, 8'd0, 8'd0, 24'd0, 1'b1, a);
  endtask

  task automatic drain(input int max_cyc);
    logic a;
    int   c;
    c = 0;
    while (exp_q.size() != 0 && c < max_cyc) begin
      step(1'b0, 8'd0, 8'd0, 8'd0, 24'd0, 1'b1, a);
      c++;
    end
    if (exp_q.size() != 0) check_val("drain_timeout", exp_q.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    luma_ch   = 8'd0;
    cb_ch     = 8'd0;
    cr_ch     = 8'd0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check_val("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_val("rst_rgb", {8'h0, red_ch, green_ch, blue_ch}, 32'd0);
    check_val("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;

    // Grey and 3-cycle latency
    step(1'b1, 8'd128, 8'd128, 8'd128, 24'h808080, 1'b1, acc);
    acc_cyc = cyc;
    drain(10);
    check_val("grey_latency", pop_cyc[$] - acc_cyc, 32'd3);

    // White then saturated red, back to back
    n0 = pop_cyc.size();
    step(1'b1, 8'd255, 8'd128, 8'd128, 24'hFFFFFF, 1'b1, acc);
    step(1'b1, 8'd76,  8'd85,  8'd255, 24'hFE0000, 1'b1, acc);
    drain(10);
    check_val("b2b_count", pop_cyc.size() - n0, 32'd2);
    if (pop_cyc.size() >= n0 + 2)
      check_val("b2b_spacing", pop_cyc[n0+1] - pop_cyc[n0], 32'd1);

    // Clamp high and low
    step(1'b1, 8'd255, 8'd128, 8'd255, 24'hFFA4FF, 1'b1, acc);
    step(1'b1, 8'd0,   8'd0,   8'd128, 24'h002C00, 1'b1, acc);
    drain(10);
    idle(2);

    // Backpressure: out_ready low for 4 cycles mid-stream
    n0   = pop_cyc.size();
    bp_i = 0;
    bp_c = 0;
    while ((bp_i < 6 || exp_q.size() != 0) && bp_c < 60) begin
      if (bp_i < 6)
        step(1'b1, bp_y[bp_i], bp_cb[bp_i], bp_cr[bp_i], bp_e[bp_i],
             !(bp_c >= 4 && bp_c < 8), acc);
      else
        step(1'b0, 8'd0, 8'd0, 8'd0, 24'd0, !(bp_c >= 4 && bp_c < 8), acc);
      if (acc) bp_i++;
      bp_c++;
    end
    check_val("bp_count", pop_cyc.size() - n0, 32'd6);
    check_val("bp_drained", exp_q.size(), 32'd0);
    idle(3);

    // Asynchronous reset with pixels in flight
    step(1'b1, 8'd128, 8'd128, 8'd128, 24'h808080, 1'b1, acc);
    step(1'b1, 8'd255, 8'd128, 8'd128, 24'hFFFFFF, 1'b1, acc);
    step(1'b1, 8'd76,  8'd85,  8'd255, 24'hFE0000, 1'b1, acc);
    in_valid = 1'b0;
    @(posedge clk);
    #2;
    check_val("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    rst = 1'b1;
    #1;
    check_val("async_rst_valid", {31'd0, out_valid}, 32'd0);
    check_val("async_rst_rgb", {8'h0, red_ch, green_ch, blue_ch}, 32'd0);
    exp_q.delete();
    @(negedge clk);
    #2;
    rst = 1'b0;
    idle(5);

    n0 = pop_cyc.size();
    step(1'b1, 8'd100, 8'd150, 8'd100, 24'h3D708B, 1'b1, acc);
    acc_cyc = cyc;
    drain(10);
    check_val("post_rst_count", pop_cyc.size() - n0, 32'd1);
    check_val("post_rst_latency", pop_cyc[$] - acc_cyc, 32'd3);
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
